// File: rtl/cpu_run_controller.sv
// Run/step/breakpoint sequencer gating the CPU clock enable. All start/stop
// decisions land on instruction boundaries; the phase counter tracks position.
module cpu_run_controller #(
  parameter int AW      = 5,
  parameter int PHASES  = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 2500
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_run_req,
  input  logic             i_step_req,
  input  logic             i_stop_req,
  input  logic             i_bp_en,
  input  logic [AW-1:0]    i_bp_addr,
  input  logic [AW-1:0]    i_pc_in,
  input  logic             i_halt_in,
  output logic             o_cpu_en,
  output logic [1:0]       o_state,
  output logic             o_at_boundary,
  output logic             o_bp_hit,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_instr_count,
  output logic [CNT_W-1:0] o_cycle_count
);

  localparam int PH_W = (PHASES > 2) ? $clog2(PHASES) : 1;
  localparam logic [PH_W-1:0]  LAST_PH = PH_W'(PHASES - 1);
  localparam logic [CNT_W-1:0] SAT     = '1;
  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT);
  localparam bit               TO_ON   = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUN     = 2'd1,
    ST_STEP    = 2'd2,
    ST_HALTED  = 2'd3
  } state_t;

  state_t           r_state;
  logic [PH_W-1:0]  r_phase;
  logic [CNT_W-1:0] r_instr_count;
  logic [CNT_W-1:0] r_cycle_count;
  logic [CNT_W-1:0] r_run_cycles;
  logic             r_armed;
  logic             r_stop_pending;
  logic             r_halt_seen;
  logic             r_bp_hit;
  logic             r_timeout;

  logic             w_en;
  logic             w_last;
  logic             w_halt;
  logic             w_stop;
  logic             w_bp;
  logic             w_to;
  logic [CNT_W-1:0] w_run_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == SAT) ? v : v + 1'b1;
  endfunction

  assign w_en      = (r_state == ST_RUN) || (r_state == ST_STEP);
  assign w_last    = w_en && (r_phase == LAST_PH);
  assign w_halt    = i_halt_in || r_halt_seen;
  // A stop request arriving on the boundary cycle itself still stops here.
  assign w_stop    = r_stop_pending || i_stop_req;
  assign w_bp      = i_bp_en && r_armed && (i_pc_in == i_bp_addr);
  assign w_run_nxt = sat_inc(r_run_cycles);
  // Timeout counts the current enabled cycle, so TIMEOUT cycles stop exactly.
  assign w_to      = TO_ON && (w_run_nxt >= TO_LIM);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= ST_STOPPED;
      r_phase        <= '0;
      r_instr_count  <= '0;
      r_cycle_count  <= '0;
      r_run_cycles   <= '0;
      r_armed        <= 1'b0;
      r_stop_pending <= 1'b0;
      r_halt_seen    <= 1'b0;
      r_bp_hit       <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      case (r_state)
        ST_STOPPED: begin
          if (!i_stop_req && (i_step_req || i_run_req)) begin
            r_state        <= i_step_req ? ST_STEP : ST_RUN;
            r_armed        <= 1'b0;
            r_bp_hit       <= 1'b0;
            r_timeout      <= 1'b0;
            r_stop_pending <= 1'b0;
            r_halt_seen    <= 1'b0;
            r_run_cycles   <= '0;
          end
        end
        ST_RUN, ST_STEP: begin
          r_phase       <= w_last ? '0 : r_phase + 1'b1;
          r_cycle_count <= sat_inc(r_cycle_count);
          r_run_cycles  <= w_run_nxt;
          if (i_stop_req) r_stop_pending <= 1'b1;
          if (!w_last) begin
            if (i_halt_in) r_halt_seen <= 1'b1;
          end else begin
            r_instr_count <= sat_inc(r_instr_count);
            if (w_halt) begin
              r_state <= ST_HALTED;
            end else if (r_state == ST_STEP || w_stop) begin
              r_state        <= ST_STOPPED;
              r_stop_pending <= 1'b0;
            end else if (w_bp) begin
              r_state  <= ST_STOPPED;
              r_bp_hit <= 1'b1;
            end else if (w_to) begin
              r_state   <= ST_STOPPED;
              r_timeout <= 1'b1;
            end else begin
              r_armed <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_cpu_en      = w_en;
  assign o_state       = r_state;
  assign o_at_boundary = (r_phase == '0);
  assign o_bp_hit      = r_bp_hit;
  assign o_timeout     = r_timeout;
  assign o_instr_count = r_instr_count;
  assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: halt, step, breakpoint, stop,
// timeout and async reset, against a small phase/PC model of the CPU.
module tb_cpu_run_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_req, step_req, stop_req, bp_en, halt_arm;
  logic [4:0]  bp_addr;
  logic [4:0]  pc_in;
  logic        halt_in;

  logic        cpu_en, at_b, bp_hit, tmo;
  logic [1:0]  state;
  logic [15:0] icnt, ccnt;
  logic        t_cpu_en, t_at_b, t_bp_hit, t_tmo;
  logic [1:0]  t_state;
  logic [15:0] t_icnt, t_ccnt;

  logic [2:0]  m_phase;
  logic [4:0]  m_pc;
  int          n_chk = 0;
  int          n_fail = 0;
  int          n;

  always #5 clk = ~clk;

  cpu_run_controller u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_run_req(run_req), .i_step_req(step_req),
    .i_stop_req(stop_req), .i_bp_en(bp_en), .i_bp_addr(bp_addr), .i_pc_in(pc_in),
    .i_halt_in(halt_in), .o_cpu_en(cpu_en), .o_state(state), .o_at_boundary(at_b),
    .o_bp_hit(bp_hit), .o_timeout(tmo), .o_instr_count(icnt), .o_cycle_count(ccnt)
  );

  cpu_run_controller #(.TIMEOUT(64)) u_to (
    .i_clk(clk), .i_rst_n(rst_n), .i_run_req(run_req), .i_step_req(step_req),
    .i_stop_req(stop_req), .i_bp_en(bp_en), .i_bp_addr(bp_addr), .i_pc_in(pc_in),
    .i_halt_in(halt_in), .o_cpu_en(t_cpu_en), .o_state(t_state), .o_at_boundary(t_at_b),
    .o_bp_hit(t_bp_hit), .o_timeout(t_tmo), .o_instr_count(t_icnt), .o_cycle_count(t_ccnt)
  );

  // CPU model: PC advances at each instruction end; on the last phase the
  // PC bus already shows the next instruction's address.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 3'd0;
      m_pc    <= 5'd0;
    end else if (cpu_en) begin
      m_phase <= m_phase + 3'd1;
      if (m_phase == 3'd7) m_pc <= m_pc + 5'd1;
    end
  end
  assign pc_in   = (m_phase == 3'd7) ? m_pc + 5'd1 : m_pc;
  assign halt_in = halt_arm && cpu_en && (m_pc == 5'd11) && (m_phase == 3'd3);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    run_req = 0; step_req = 0; stop_req = 0;
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic pulse_run();
    run_req = 1;
    tick();
    run_req = 0;
  endtask

  task automatic pulse_step();
    step_req = 1;
    tick();
    step_req = 0;
  endtask

  initial begin
    bp_en = 0; bp_addr = 5'd0; halt_arm = 0;
    do_reset();
    chk("rst_state", state, 0);
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_at_b", at_b, 1);
    chk("rst_icnt", icnt, 0);
    chk("rst_ccnt", ccnt, 0);
    chk("rst_flags", {bp_hit, tmo}, 0);

    // halt raised mid-instruction 12
    halt_arm = 1;
    pulse_run();
    chk("run_cpu_en", cpu_en, 1);
    for (int i = 0; i < 300 && state != 2'd3; i++) tick();
    chk("halt_state", state, 3);
    chk("halt_icnt", icnt, 12);
    chk("halt_ccnt", ccnt, 96);
    chk("halt_cpu_en", cpu_en, 0);
    chk("halt_at_b", at_b, 1);
    tick(); tick();
    chk("halt_hold", {state, ccnt}, {2'd3, 16'd96});
    halt_arm = 0;

    // single step
    do_reset();
    pulse_step();
    n = 0;
    while (cpu_en && n < 20) begin n++; tick(); end
    chk("step_len", n, 8);
    chk("step_icnt", icnt, 1);
    chk("step_state", state, 0);
    chk("step_at_b", at_b, 1);
    pulse_step();
    for (int i = 0; i < 20 && cpu_en; i++) tick();
    chk("step2_icnt", icnt, 2);
    chk("step2_ccnt", ccnt, 16);

    // breakpoint at 0x05
    do_reset();
    bp_en = 1; bp_addr = 5'd5;
    pulse_run();
    for (int i = 0; i < 200 && cpu_en; i++) tick();
    chk("bp_state", state, 0);
    chk("bp_hit", bp_hit, 1);
    chk("bp_icnt", icnt, 5);
    chk("bp_at_b", at_b, 1);
    pulse_run();
    chk("bp_clr", bp_hit, 0);
    for (int i = 0; i < 20; i++) tick();
    chk("bp_rerun_state", state, 1);
    chk("bp_rerun_icnt", icnt, 7);
    chk("bp_rerun_ccnt", ccnt, 60);
    bp_en = 0;

    // stop at phase 3; run/step pulses meanwhile are ignored
    for (int i = 0; i < 7; i++) tick();
    stop_req = 1;
    tick();
    stop_req = 0;
    n = 1;
    while (cpu_en && n < 20) begin
      step_req = (n == 2);
      run_req  = (n == 3);
      tick();
      n++;
    end
    step_req = 0; run_req = 0;
    chk("stop_len", n, 5);
    chk("stop_state", state, 0);
    chk("stop_at_b", at_b, 1);
    chk("stop_icnt", icnt, 9);
    chk("stop_ccnt", ccnt, 72);
    tick(); tick();
    chk("stop_no_queue", {cpu_en, state}, 3'd0);

    // timeout on the TIMEOUT=64 instance
    do_reset();
    pulse_run();
    for (int i = 0; i < 200 && t_state == 2'd1; i++) tick();
    chk("to_state", t_state, 0);
    chk("to_flag", t_tmo, 1);
    chk("to_icnt", t_icnt, 8);
    chk("to_ccnt", t_ccnt, 64);
    chk("to_cpu_en", t_cpu_en, 0);
    pulse_run();
    chk("to_clr", t_tmo, 0);
    chk("to_rerun", t_state, 1);

    // async reset at phase 4 of RUN
    do_reset();
    pulse_run();
    for (int i = 0; i < 4; i++) tick();
    chk("pre_arst_at_b", at_b, 0);
    rst_n = 0;
    #1;
    chk("arst_cpu_en", cpu_en, 0);
    chk("arst_state", state, 0);
    chk("arst_cnt", {icnt, ccnt}, 0);
    chk("arst_at_b", at_b, 1);
    #1;
    rst_n = 1;
    pulse_run();
    for (int i = 0; i < 16; i++) tick();
    chk("post_arst_icnt", icnt, 2);
    chk("post_arst_ccnt", ccnt, 16);
    chk("post_arst_state", state, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
